// File: rtl/conv_pkg.sv
// Shared widths, element types and arithmetic helpers for the convolution MAC unit.
package conv_pkg;
   localparam int DATA_W = 8;
   localparam int PROD_W = 17;
   localparam int ACC_W  = 24;

   typedef logic        [DATA_W-1:0] act_t;
   typedef logic signed [DATA_W-1:0] wgt_t;
   typedef logic signed [PROD_W-1:0] prod_t;
   typedef logic signed [ACC_W-1:0]  acc_t;

   // Activations are unsigned, so zero-extend to 9 bits before the signed multiply.
   function automatic prod_t mul_aw(input act_t a, input wgt_t b);
      return prod_t'($signed({1'b0, a})) * prod_t'(b);
   endfunction

   function automatic acc_t relu(input acc_t x);
      return x[ACC_W-1] ? '0 : x;
   endfunction
endpackage

// File: rtl/conv_adder_tree.sv
// Combinational balanced adder tree: sign-extends N products and sums them to acc_t.
module conv_adder_tree
   import conv_pkg::*;
#(
   parameter int N = 9
) (
   input  prod_t [N-1:0] i_prod,
   output acc_t          o_sum
);
   localparam int LVL = (N > 1) ? $clog2(N) : 0;
   localparam int P   = 1 << LVL;

   // Heap layout: leaves at [P .. 2P-1], node k = node 2k + node 2k+1, root at 1.
   acc_t w_node [1:2*P-1];

   for (genvar k = 0; k < P; k++) begin : g_leaf
      if (k < N) begin : g_used
         assign w_node[P+k] = acc_t'($signed(i_prod[k]));
      end else begin : g_pad
         assign w_node[P+k] = '0;
      end
   end

   for (genvar k = 1; k < P; k++) begin : g_node
      assign w_node[k] = w_node[2*k] + w_node[2*k+1];
   end

   assign o_sum = w_node[1];
endmodule

// File: rtl/conv_unit.sv
// K_H x K_W convolution MAC: unsigned activations times signed weights, summed to 24 bits.
// Optional CONV_UNIT_RELU_EN clamps negative sums to zero in the output stage.
module conv_unit
   import conv_pkg::*;
#(
   parameter int K_H = 3,
   parameter int K_W = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  act_t [0:K_H-1][0:K_W-1]       conv_win,
   input  wgt_t [0:K_H-1][0:K_W-1]       w,
   output logic                          out_valid,
   output acc_t                          result
);
   localparam int N = K_H * K_W;

   prod_t [N-1:0] w_prod;
   prod_t [N-1:0] r_prod;
   acc_t          w_sum;
   acc_t          w_final;
   acc_t          r_sum;
   logic [2:0]    r_vld_pipe;

   for (genvar i = 0; i < K_H; i++) begin : g_row
      for (genvar j = 0; j < K_W; j++) begin : g_col
         assign w_prod[i*K_W+j] = mul_aw(conv_win[i][j], $signed(w[i][j]));
      end
   end

   conv_adder_tree #(.N(N)) u_tree (
      .i_prod (r_prod),
      .o_sum  (w_sum)
   );

`ifdef CONV_UNIT_RELU_EN
   assign w_final = relu(r_sum);
`else
   assign w_final = r_sum;
`endif

   // Products, tree sum, then the output register: result lands two edges after sampling.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld_pipe <= '0;
         r_prod     <= '0;
         r_sum      <= '0;
         result     <= '0;
      end else begin
         r_vld_pipe <= {r_vld_pipe[1:0], in_valid};
         if (in_valid)      r_prod <= w_prod;
         if (r_vld_pipe[0]) r_sum  <= w_sum;
         if (r_vld_pipe[1]) result <= w_final;
      end
   end

   assign out_valid = r_vld_pipe[2];
endmodule

// File: tb/tb_conv_unit.sv
// Self-checking bench for conv_unit: directed table, reset corners, randomized traffic vs model.
module tb_conv_unit;
   typedef logic [0:2][0:2][7:0] win_t;

   typedef struct {
      string name;
      win_t  win;
      win_t  wt;
      int    exp;
   } vec_t;

   typedef struct {
      int due;
      int val;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst;
   logic               in_valid;
   win_t               win;
   win_t               wt;
   logic               out_valid;
   logic signed [23:0] result;

   logic               iv1;
   logic [0:0][0:0][7:0] win1;
   logic [0:0][0:0][7:0] wt1;
   logic               ov1;
   logic signed [23:0] res1;

   conv_unit #(.K_H(3), .K_W(3)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .conv_win(win), .w(wt),
      .out_valid(out_valid), .result(result)
   );

   conv_unit #(.K_H(1), .K_W(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(iv1), .conv_win(win1), .w(wt1),
      .out_valid(ov1), .result(res1)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic signed [31:0] got, input logic signed [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   function automatic int clamp(input int s);
`ifdef CONV_UNIT_RELU_EN
      return (s < 0) ? 0 : s;
`else
      return s;
`endif
   endfunction

   function automatic int golden(input win_t a, input win_t b);
      int s;
      s = 0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            s += int'(a[i][j]) * int'($signed(b[i][j]));
      return clamp(s);
   endfunction

   function automatic win_t fill(input logic [7:0] v);
      win_t t;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            t[i][j] = v;
      return t;
   endfunction

   function automatic win_t rnd_win();
      win_t t;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            t[i][j] = 8'($urandom);
      return t;
   endfunction

   // Reference model: each accepted window becomes due two edges later; reset drops all.
   exp_t q[$];
   int   cyc    = 0;
   logic ev     = 1'b0;
   int   er     = 0;
   logic mon_en = 1'b0;

   initial forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
         q.delete();
         ev = 1'b0;
         er = 0;
      end else begin
         ev = 1'b0;
         if (q.size() > 0 && q[0].due == cyc) begin
            ev = 1'b1;
            er = q[0].val;
            void'(q.pop_front());
         end
         if (in_valid) q.push_back('{due: cyc + 2, val: golden(win, wt)});
      end
   end

   initial forever begin
      @(negedge clk);
      if (mon_en) begin
         chk("mon_out_valid", {31'd0, out_valid}, {31'd0, ev});
         chk("mon_result", $signed(result), er);
      end
   end

   vec_t tv[4];

   initial begin
      win_t a;
      int   e;

      tv[0] = '{name: "all_ones", win: fill(8'd1), wt: fill(8'd1), exp: 9};
      a = '0; a[1][1] = 8'd200;
      tv[1].name = "unsigned_center"; tv[1].win = a;
      a = '0; a[1][1] = 8'hFF;
      tv[1].wt = a; tv[1].exp = clamp(-200);
      tv[2] = '{name: "max_neg", win: fill(8'd255), wt: fill(8'h80), exp: clamp(-293760)};
      tv[3] = '{name: "max_pos", win: fill(8'd255), wt: fill(8'h7F), exp: 291465};

      rst = 1'b1; in_valid = 1'b0; win = '0; wt = '0;
      iv1 = 1'b0; win1 = '0; wt1 = '0;
      repeat (3) @(negedge clk);
      chk("reset_out_valid", {31'd0, out_valid}, 0);
      chk("reset_result", $signed(result), 0);
      chk("reset_out_valid_1x1", {31'd0, ov1}, 0);
      rst = 1'b0;
      mon_en = 1'b1;

      for (int k = 0; k < 4; k++) begin
         win = tv[k].win; wt = tv[k].wt; in_valid = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
         chk({tv[k].name, "_lat1"}, {31'd0, out_valid}, 0);
         @(negedge clk);
         chk({tv[k].name, "_lat2"}, {31'd0, out_valid}, 0);
         @(negedge clk);
         chk({tv[k].name, "_valid"}, {31'd0, out_valid}, 1);
         chk({tv[k].name, "_result"}, $signed(result), tv[k].exp);
         @(negedge clk);
         chk({tv[k].name, "_drop"}, {31'd0, out_valid}, 0);
         chk({tv[k].name, "_hold"}, $signed(result), tv[k].exp);
      end

      // 1x1 kernel extreme
      iv1 = 1'b1; win1[0][0] = 8'd255; wt1[0][0] = 8'h80;
      @(negedge clk);
      iv1 = 1'b0;
      repeat (2) @(negedge clk);
      chk("k1x1_valid", {31'd0, ov1}, 1);
      chk("k1x1_result", $signed(res1), clamp(-32640));

      // five back-to-back random windows
      for (int k = 0; k < 5; k++) begin
         win = rnd_win(); wt = rnd_win(); in_valid = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      repeat (4) @(negedge clk);

      // reset while two windows are in flight
      win = rnd_win(); wt = rnd_win(); in_valid = 1'b1;
      @(negedge clk);
      win = rnd_win(); wt = rnd_win();
      @(negedge clk);
      in_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("midreset_out_valid", {31'd0, out_valid}, 0);
         chk("midreset_result", $signed(result), 0);
         @(negedge clk);
      end

      // reset wins over a same-cycle input
      win = fill(8'd3); wt = fill(8'd5); in_valid = 1'b1; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("rst_prio_out_valid", {31'd0, out_valid}, 0);
      end

      // first window after reset
      win = rnd_win(); wt = rnd_win(); in_valid = 1'b1;
      e = golden(win, wt);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("post_reset_valid", {31'd0, out_valid}, 1);
      chk("post_reset_result", $signed(result), e);

      // randomized traffic with sparse resets
      for (int k = 0; k < 300; k++) begin
         in_valid = ($urandom_range(0, 9) < 6);
         rst      = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 7) == 0) begin
            win = fill(8'd255);
            wt  = ($urandom_range(0, 1) == 1) ? fill(8'h80) : fill(8'h7F);
         end else begin
            win = rnd_win(); wt = rnd_win();
         end
         @(negedge clk);
      end
      in_valid = 1'b0; rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("drain_empty", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
